pe_result_pingpong_cache: RTL and testbench

//  Parametrised, double-buffered result cache between the N_ROWS x N_COLS PE array and the per-column writeback.
//  - The PE array writes the whole result tile in one save beat, either as a load or as an accumulate (partial sums over K tiles).
//  - A committed tile is drained column by column as independent serial bursts (sop/vld/eop).
//  - The two banks let the PE array fill the next tile while the current one drains.

---
 rtl/pe_result_pingpong_cache.sv | 180 ++++++++++++++++++
 tb/tb_pe_result_pingpong_cache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_pingpong_cache.sv
// rtl/pe_result_pingpong_cache.sv - double-buffered PE result tile cache with per-column serial drain
// Save beats load or accumulate a whole tile; committed tiles drain as independent column bursts.
module pe_result_pingpong_cache #(
   parameter int DATA_W = 16,
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            save_sop,
   input  logic                            save_acc,
   input  logic                            save_last,
   input  logic [N_ROWS*N_COLS*DATA_W-1:0] save_data,
   output logic                            save_ready,
   input  logic [N_COLS-1:0]               rd_sop,
   output logic [N_COLS-1:0]               rd_vld,
   output logic [N_COLS-1:0]               rd_eop,
   output logic [N_COLS*DATA_W-1:0]        rd_data,
   output logic [1:0]                      full_cnt,
   output logic                            err_drop
);

   localparam int N_WORDS = N_ROWS * N_COLS;
   localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_e;
   typedef enum logic [1:0] {C_IDLE, C_BURST, C_DONE} col_st_e;

   bank_st_e                 bank_q [2];
   bank_st_e                 bank_d [2];
   logic                     wr_bank_q, wr_bank_d;
   logic                     rd_bank_q, rd_bank_d;
   logic                     err_q, err_d;
   logic [DATA_W-1:0]        mem_q [2][N_WORDS];
   logic [DATA_W-1:0]        wr_word [N_WORDS];
   col_st_e                  col_q [N_COLS];
   col_st_e                  col_d [N_COLS];
   logic [ROW_W-1:0]         row_q [N_COLS];
   logic [ROW_W-1:0]         row_d [N_COLS];
   logic [N_COLS-1:0]        vld_q, vld_d, eop_q, eop_d, rd_drop;
   logic [N_COLS*DATA_W-1:0] data_q, data_d;
   logic                     save_ok, rd_full, oth_full, all_fin, drain_done;

   function automatic logic [DATA_W-1:0] add_word(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      if (SAT_EN && (s[DATA_W] != s[DATA_W-1]))
         add_word = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         add_word = s[DATA_W-1:0];
   endfunction

   assign save_ready = (bank_q[wr_bank_q] != B_FULL);
   assign save_ok    = save_sop & save_ready;
   assign rd_full    = (bank_q[rd_bank_q] == B_FULL);
   assign oth_full   = (bank_q[~rd_bank_q] == B_FULL);
   assign drain_done = rd_full & all_fin;

   assign rd_vld   = vld_q;
   assign rd_eop   = eop_q;
   assign rd_data  = data_q;
   assign err_drop = err_q;
   assign full_cnt = {1'b0, bank_q[0] == B_FULL} + {1'b0, bank_q[1] == B_FULL};

   // An EMPTY bank holds stale words, so accumulation starts from zero there.
   always_comb begin
      for (int w = 0; w < N_WORDS; w++) begin
         logic [DATA_W-1:0] base;
         base = (bank_q[wr_bank_q] == B_EMPTY) ? '0 : mem_q[wr_bank_q][w];
         wr_word[w] = save_acc ? add_word(base, save_data[w*DATA_W +: DATA_W])
                               : save_data[w*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      all_fin = 1'b1;
      for (int c = 0; c < N_COLS; c++) begin
         if (!(col_q[c] == C_DONE || (col_q[c] == C_BURST && eop_q[c])))
            all_fin = 1'b0;
      end
   end

   // On the drain edge a fresh rd_sop is steered straight to the other bank.
   always_comb begin
      logic [ROW_W-1:0] nxt_row;
      logic             start_bank, start_ok, can_start;
      rd_drop = '0;
      vld_d   = '0;
      eop_d   = '0;
      data_d  = '0;
      start_bank = drain_done ? ~rd_bank_q : rd_bank_q;
      start_ok   = drain_done ? oth_full : rd_full;
      for (int c = 0; c < N_COLS; c++) begin
         col_d[c]  = col_q[c];
         row_d[c]  = row_q[c];
         nxt_row   = row_q[c] + 1'b1;
         can_start = drain_done || (col_q[c] == C_IDLE);
         if (drain_done) begin
            col_d[c] = C_IDLE;
         end else if (col_q[c] == C_BURST) begin
            if (eop_q[c]) begin
               col_d[c] = C_DONE;
            end else begin
               row_d[c] = nxt_row;
               vld_d[c] = 1'b1;
               eop_d[c] = (nxt_row == ROW_W'(N_ROWS - 1));
               data_d[c*DATA_W +: DATA_W] = mem_q[rd_bank_q][c*N_ROWS + int'(nxt_row)];
            end
         end
         if (rd_sop[c]) begin
            if (can_start && start_ok) begin
               col_d[c] = C_BURST;
               row_d[c] = '0;
               vld_d[c] = 1'b1;
               eop_d[c] = (N_ROWS == 1);
               data_d[c*DATA_W +: DATA_W] = mem_q[start_bank][c*N_ROWS];
            end else begin
               rd_drop[c] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      err_d     = err_q | (save_sop & ~save_ready) | (|rd_drop);
      for (int b = 0; b < 2; b++) begin
         bank_d[b] = bank_q[b];
         if (save_ok && wr_bank_q == 1'(b))
            bank_d[b] = save_last ? B_FULL : B_FILLING;
         if (drain_done && rd_bank_q == 1'(b))
            bank_d[b] = B_EMPTY;
      end
      if (save_ok && save_last)
         wr_bank_d = ~wr_bank_q;
      if (drain_done)
         rd_bank_d = ~rd_bank_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q[0] <= B_EMPTY;
         bank_q[1] <= B_EMPTY;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         err_q     <= 1'b0;
         vld_q     <= '0;
         eop_q     <= '0;
         data_q    <= '0;
         for (int c = 0; c < N_COLS; c++) begin
            col_q[c] <= C_IDLE;
            row_q[c] <= '0;
         end
      end else begin
         bank_q[0] <= bank_d[0];
         bank_q[1] <= bank_d[1];
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         err_q     <= err_d;
         vld_q     <= vld_d;
         eop_q     <= eop_d;
         data_q    <= data_d;
         for (int c = 0; c < N_COLS; c++) begin
            col_q[c] <= col_d[c];
            row_q[c] <= row_d[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (save_ok) begin
         for (int w = 0; w < N_WORDS; w++)
            mem_q[wr_bank_q][w] <= wr_word[w];
      end
   end

endmodule

// File: tb/tb_pe_result_pingpong_cache.sv
// tb/tb_pe_result_pingpong_cache.sv - scoreboard bench for pe_result_pingpong_cache
// A saturating and a wrapping instance share all inputs; burst words are checked against queued tiles.
module tb_pe_result_pingpong_cache;

   localparam int DW = 16;
   localparam int NR = 8;
   localparam int NC = 8;
   localparam int NW = NR * NC;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              save_sop = 1'b0, save_acc = 1'b0, save_last = 1'b0;
   logic [NW*DW-1:0]  sd = '0;
   logic [NC-1:0]     rd_sop = '0;
   logic              save_ready, save_ready_w, err_drop, err_w;
   logic [NC-1:0]     rd_vld, rd_eop, rd_vld_w, rd_eop_w;
   logic [NC*DW-1:0]  rd_data, rd_data_w;
   logic [1:0]        full_cnt, full_cnt_w;

   typedef struct packed {
      logic [2:0]  col;
      logic [15:0] ds;
      logic [15:0] dw;
      logic        eop;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [15:0] tile_sat [NW];
   logic [15:0] tile_wrap [NW];
   int          n_assert = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   pe_result_pingpong_cache #(.DATA_W(DW), .N_ROWS(NR), .N_COLS(NC), .SAT_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .save_sop(save_sop), .save_acc(save_acc), .save_last(save_last),
      .save_data(sd), .save_ready(save_ready), .rd_sop(rd_sop), .rd_vld(rd_vld),
      .rd_eop(rd_eop), .rd_data(rd_data), .full_cnt(full_cnt), .err_drop(err_drop));

   pe_result_pingpong_cache #(.DATA_W(DW), .N_ROWS(NR), .N_COLS(NC), .SAT_EN(1'b0)) u_dut_wrap (
      .clk(clk), .rst(rst), .save_sop(save_sop), .save_acc(save_acc), .save_last(save_last),
      .save_data(sd), .save_ready(save_ready_w), .rd_sop(rd_sop), .rd_vld(rd_vld_w),
      .rd_eop(rd_eop_w), .rd_data(rd_data_w), .full_cnt(full_cnt_w), .err_drop(err_w));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < NC; c++) begin
            if (rd_vld[c]) begin
               if (exp_q.size() == 0) begin
                  check_eq("unexp_vld", 32'(rd_vld[c]), 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check_eq("burst_col", c, 32'(mon_e.col));
                  check_eq("burst_data", rd_data[c*DW +: DW], mon_e.ds);
                  check_eq("burst_vld_wrap", 32'(rd_vld_w[c]), 32'd1);
                  check_eq("burst_data_wrap", rd_data_w[c*DW +: DW], mon_e.dw);
                  check_eq("burst_eop", 32'(rd_eop[c]), 32'(mon_e.eop));
               end
            end else begin
               check_eq("idle_data", rd_data[c*DW +: DW], 32'd0);
               check_eq("idle_eop", 32'(rd_eop[c]), 32'd0);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      save_sop = 1'b0;
      rd_sop = '0;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_save_ready", 32'(save_ready), 32'd1);
      check_eq("rst_full_cnt", 32'(full_cnt), 32'd0);
      check_eq("rst_err_drop", 32'(err_drop), 32'd0);
      check_eq("rst_rd_vld", 32'(rd_vld), 32'd0);
      check_eq("rst_rd_eop", 32'(rd_eop), 32'd0);
      check_eq("rst_rd_data", 32'(rd_data != '0), 32'd0);
      check_eq("rst_wrap_state", {27'd0, save_ready_w, full_cnt_w, err_w, |rd_eop_w}, 32'h10);
      mon_en = 1'b1;
   endtask

   task automatic save_beat(input logic acc, input logic last);
      save_sop  = 1'b1;
      save_acc  = acc;
      save_last = last;
      tick();
      save_sop  = 1'b0;
   endtask

   task automatic tile_from_sd();
      for (int w = 0; w < NW; w++) begin
         tile_sat[w]  = sd[w*DW +: DW];
         tile_wrap[w] = sd[w*DW +: DW];
      end
   endtask

   task automatic read_cols(input logic [NC-1:0] mask, input int nrows);
      rd_sop = mask;
      for (int r = 0; r < nrows; r++)
         for (int c = 0; c < NC; c++)
            if (mask[c])
               exp_q.push_back('{col: 3'(c), ds: tile_sat[c*NR+r], dw: tile_wrap[c*NR+r],
                                 eop: (r == NR-1)});
      tick();
      rd_sop = '0;
   endtask

   task automatic wait_q();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check_eq("drain_timeout", exp_q.size(), 32'd0);
      tick();
      tick();
   endtask

   initial begin
      do_reset();

      // single tile load, col0 first, then the rest
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            sd[(c*NR+r)*DW +: DW] = 16'(16*c + r);
      tile_from_sd();
      save_beat(1'b0, 1'b1);
      tick();
      check_eq("load_full_cnt", 32'(full_cnt), 32'd1);
      read_cols(8'h01, NR);
      check_eq("load_latency", 32'(rd_vld), 32'h01);
      check_eq("load_full_cnt_burst", 32'(full_cnt), 32'd1);
      wait_q();
      read_cols(8'hFE, NR);
      wait_q();
      check_eq("load_drained", 32'(full_cnt), 32'd0);

      // accumulate over three beats
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'h0100;
      save_beat(1'b0, 1'b0);
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'h0010;
      save_beat(1'b1, 1'b0);
      check_eq("acc_ready_filling", 32'(save_ready), 32'd1);
      save_beat(1'b1, 1'b1);
      for (int w = 0; w < NW; w++) begin
         tile_sat[w] = 16'h0120;
         tile_wrap[w] = 16'h0120;
      end
      read_cols(8'hFF, NR);
      wait_q();

      // saturation vs wrap at both ends
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = (w < NW/2) ? 16'h7FF0 : 16'h8005;
      save_beat(1'b0, 1'b0);
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = (w < NW/2) ? 16'h0020 : 16'hFFF0;
      save_beat(1'b1, 1'b1);
      for (int w = 0; w < NW; w++) begin
         tile_sat[w]  = (w < NW/2) ? 16'h7FFF : 16'h8000;
         tile_wrap[w] = (w < NW/2) ? 16'h8010 : 16'h7FF5;
      end
      read_cols(8'hFF, NR);
      wait_q();

      // ping-pong: commit B while A drains, third save dropped
      do_reset();
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'(16'h1000 + w);
      tile_from_sd();
      save_beat(1'b0, 1'b1);
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'(16'h2000 + w);
      save_sop = 1'b1;
      save_acc = 1'b0;
      save_last = 1'b1;
      read_cols(8'hFF, NR);
      save_sop = 1'b0;
      tick();
      check_eq("pp_save_ready", 32'(save_ready), 32'd0);
      check_eq("pp_full_cnt", 32'(full_cnt), 32'd2);
      check_eq("pp_err_before", 32'(err_drop), 32'd0);
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'hDEAD;
      save_beat(1'b0, 1'b1);
      check_eq("pp_err_drop", 32'(err_drop), 32'd1);
      wait_q();
      check_eq("pp_full_cnt_after_a", 32'(full_cnt), 32'd1);
      check_eq("pp_ready_after_a", 32'(save_ready), 32'd1);
      for (int w = 0; w < NW; w++) begin
         tile_sat[w] = 16'(16'h2000 + w);
         tile_wrap[w] = 16'(16'h2000 + w);
      end
      read_cols(8'hFF, NR);
      wait_q();
      check_eq("pp_full_cnt_end", 32'(full_cnt), 32'd0);

      // read errors
      do_reset();
      rd_sop = 8'hFF;
      tick();
      rd_sop = '0;
      check_eq("nobank_err", 32'(err_drop), 32'd1);
      tick();
      check_eq("nobank_vld", 32'(rd_vld), 32'd0);
      do_reset();
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'(16'h3000 + w);
      tile_from_sd();
      save_beat(1'b0, 1'b1);
      read_cols(8'h28, NR);
      tick();
      tick();
      check_eq("rderr_err_clean", 32'(err_drop), 32'd0);
      rd_sop = 8'h08;
      tick();
      rd_sop = '0;
      check_eq("rderr_in_burst", 32'(err_drop), 32'd1);
      wait_q();
      rd_sop = 8'h08;
      tick();
      rd_sop = '0;
      tick();
      tick();
      check_eq("rderr_done_vld", 32'(rd_vld), 32'd0);
      check_eq("rderr_full_cnt", 32'(full_cnt), 32'd1);
      read_cols(8'hD7, NR);
      wait_q();
      check_eq("rderr_drained", 32'(full_cnt), 32'd0);
      check_eq("rderr_ready", 32'(save_ready), 32'd1);

      // accumulate into EMPTY bank over stale words, then reset mid-burst
      do_reset();
      for (int w = 0; w < NW; w++) sd[w*DW +: DW] = 16'(16'h0005 + w);
      tile_from_sd();
      save_beat(1'b1, 1'b1);
      read_cols(8'h01, 5);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check_eq("mid_rst_vld", 32'(rd_vld), 32'd0);
      check_eq("mid_rst_eop", 32'(rd_eop), 32'd0);
      rst = 1'b0;
      tick();
      check_eq("mid_rst_full_cnt", 32'(full_cnt), 32'd0);
      check_eq("mid_rst_ready", 32'(save_ready), 32'd1);
      check_eq("mid_rst_queue", exp_q.size(), 32'd0);
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
